// File: rtl/reg_cmd_pkg.sv
// Shared types and default constants for the register-file command controller.
// No logic; the state encoding and opcode defaults live here so the bench and RTL agree.
package reg_cmd_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 4;
  localparam int RF_DEPTH_DEF = 8;
  localparam int FRAME_TO_DEF = 255;
  localparam int RD_TO_DEF    = 4;
  localparam int TMR_W        = 8;

  localparam logic [7:0] WR_CMD_DEF   = 8'hAA;
  localparam logic [7:0] RD_CMD_DEF   = 8'hBB;
  localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

endpackage

// File: rtl/reg_cmd_timeout.sv
// Loadable down-counter; expired pulses in the last cycle of a loaded window unless reloaded.
// Latency: load takes effect next cycle; no backpressure.
module reg_cmd_timeout #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // A window of load_val cycles ends on the cycle the count reads 1.
  assign expired = (cnt == W'(1)) && !load;

endmodule

// File: rtl/reg_cmd_ctrl.sv
// UART byte-stream parser driving the register-file port; WrEn/RdEn one cycle after the last byte.
// Read reply goes out once TX_Busy is seen low; bytes arriving while a read is in flight are dropped.
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int                    DATA_WIDTH    = DATA_W_DEF,
  parameter int                    ADDR_WIDTH    = ADDR_W_DEF,
  parameter int                    RF_DEPTH      = RF_DEPTH_DEF,
  parameter logic [DATA_WIDTH-1:0] WR_CMD        = WR_CMD_DEF,
  parameter logic [DATA_WIDTH-1:0] RD_CMD        = RD_CMD_DEF,
  parameter logic [DATA_WIDTH-1:0] ERR_BYTE      = ERR_BYTE_DEF,
  parameter int                    FRAME_TIMEOUT = FRAME_TO_DEF,
  parameter int                    RD_TIMEOUT    = RD_TO_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_Data,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  TX_Busy,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] TX_P_Data,
  output logic                  TX_D_VLD,
  output logic                  Ctrl_Busy
);

  state_t           state;
  logic             wr_addr_ok;
  logic             rx_in_range;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expired;

  assign rx_in_range = (RF_DEPTH > int'(RX_P_Data));

  // Frame window restarts on every accepted byte; the read window also covers the RdEn cycle.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(FRAME_TIMEOUT);
    case (state)
      IDLE:    tmr_load = RX_D_VLD && (RX_P_Data == WR_CMD || RX_P_Data == RD_CMD);
      WR_ADDR: tmr_load = RX_D_VLD;
      RD_ADDR: begin
        tmr_load = RX_D_VLD && rx_in_range;
        tmr_val  = TMR_W'(RD_TIMEOUT + 1);
      end
      default: tmr_load = 1'b0;
    endcase
  end

  reg_cmd_timeout #(.W(TMR_W)) u_timeout (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      wr_addr_ok <= 1'b0;
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      Address    <= '0;
      WrData     <= '0;
      TX_P_Data  <= '0;
      TX_D_VLD   <= 1'b0;
      Ctrl_Busy  <= 1'b0;
    end else begin
      WrEn <= 1'b0;
      RdEn <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_D_VLD && RX_P_Data == WR_CMD) begin
            state     <= WR_ADDR;
            Ctrl_Busy <= 1'b1;
          end else if (RX_D_VLD && RX_P_Data == RD_CMD) begin
            state     <= RD_ADDR;
            Ctrl_Busy <= 1'b1;
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            Address    <= RX_P_Data[ADDR_WIDTH-1:0];
            wr_addr_ok <= rx_in_range;
            state      <= WR_DATA;
          end else if (tmr_expired) begin
            state     <= IDLE;
            Ctrl_Busy <= 1'b0;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            if (wr_addr_ok) begin
              WrData <= RX_P_Data;
              WrEn   <= 1'b1;
            end
            state     <= IDLE;
            Ctrl_Busy <= 1'b0;
          end else if (tmr_expired) begin
            state     <= IDLE;
            Ctrl_Busy <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_Data[ADDR_WIDTH-1:0];
            if (rx_in_range) begin
              RdEn  <= 1'b1;
              state <= RD_WAIT;
            end else begin
              TX_P_Data <= ERR_BYTE;
              TX_D_VLD  <= !TX_Busy;
              state     <= TX_SEND;
            end
          end else if (tmr_expired) begin
            state     <= IDLE;
            Ctrl_Busy <= 1'b0;
          end
        end
        RD_WAIT: begin
          // Strobe is launched on entry when the transmitter is already idle, saving a cycle.
          if (RdData_Valid) begin
            TX_P_Data <= RdData;
            TX_D_VLD  <= !TX_Busy;
            state     <= TX_SEND;
          end else if (tmr_expired) begin
            TX_P_Data <= ERR_BYTE;
            TX_D_VLD  <= !TX_Busy;
            state     <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (TX_D_VLD) begin
            TX_D_VLD  <= 1'b0;
            state     <= IDLE;
            Ctrl_Busy <= 1'b0;
          end else if (!TX_Busy) begin
            TX_D_VLD <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          TX_D_VLD  <= 1'b0;
          Ctrl_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl: vector table of single commands plus timeout/busy/reset sequences.
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_Data;
  logic       RX_D_VLD;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       TX_Busy;
  logic       WrEn, RdEn, TX_D_VLD, Ctrl_Busy;
  logic [3:0] Address;
  logic [7:0] WrData, TX_P_Data;

  always #5 CLK = ~CLK;

  reg_cmd_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_P_Data    (RX_P_Data),
    .RX_D_VLD     (RX_D_VLD),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .TX_Busy      (TX_Busy),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .TX_P_Data    (TX_P_Data),
    .TX_D_VLD     (TX_D_VLD),
    .Ctrl_Busy    (Ctrl_Busy)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int         wr_cnt = 0, rd_cnt = 0, tx_cnt = 0;
  int         wr_cyc = 0, rd_cyc = 0, tx_cyc = 0;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, tx_dat;
  int         tx_bad = 0, both_hi = 0, long_hi = 0;
  logic       prev_wr = 1'b0, prev_rd = 1'b0;

  always @(negedge CLK) begin
    if (WrEn === 1'b1) begin
      wr_cnt++; wr_cyc = cyc; wr_addr = Address; wr_data = WrData;
    end
    if (RdEn === 1'b1) begin
      rd_cnt++; rd_cyc = cyc; rd_addr = Address;
    end
    if (TX_D_VLD === 1'b1) begin
      tx_cnt++; tx_cyc = cyc; tx_dat = TX_P_Data;
      if (TX_Busy === 1'b1) tx_bad++;
    end
    if (WrEn === 1'b1 && RdEn === 1'b1) both_hi++;
    if ((WrEn === 1'b1 && prev_wr) || (RdEn === 1'b1 && prev_rd)) long_hi++;
    prev_wr = (WrEn === 1'b1);
    prev_rd = (RdEn === 1'b1);
  end

  int n_run = 0, n_fail = 0;
  int last_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_now(input logic [7:0] b);
    RX_P_Data = b;
    RX_D_VLD  = 1'b1;
    last_n    = cyc;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    send_now(b);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  typedef struct {
    logic       is_rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_wr;
    logic       exp_rd;
    logic       exp_tx;
    logic [7:0] exp_dat;
    int         exp_lat;
  } vec_t;

  vec_t vt[8];

  task automatic reset_chk(input string nm);
    chk({nm, "_outs"}, {WrEn, RdEn, Address, WrData, TX_P_Data, TX_D_VLD}, 32'h0);
    chk({nm, "_busy"}, Ctrl_Busy, 32'h0);
  endtask

  initial begin
    int w0, r0, t0, f, n0;
    vt[0] = '{1'b0, 8'h03, 8'h5C, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vt[1] = '{1'b0, 8'h07, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vt[2] = '{1'b0, 8'h0A, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    vt[3] = '{1'b0, 8'h13, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    vt[4] = '{1'b1, 8'h02, 8'h81, 1'b0, 1'b1, 1'b1, 8'h81, 3};
    vt[5] = '{1'b1, 8'h0C, 8'h55, 1'b0, 1'b0, 1'b1, 8'hEE, 1};
    vt[6] = '{1'b1, 8'h07, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 3};
    vt[7] = '{1'b1, 8'h08, 8'h66, 1'b0, 1'b0, 1'b1, 8'hEE, 1};

    // Reset with X on every input beforehand.
    RST = 1'b1; RX_P_Data = 'x; RX_D_VLD = 1'bx; RdData = 'x; RdData_Valid = 1'bx; TX_Busy = 1'bx;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    reset_chk("reset");
    RX_P_Data = '0; RX_D_VLD = 1'b0; RdData = '0; RdData_Valid = 1'b0; TX_Busy = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt;
      send(vt[i].is_rd ? 8'hBB : 8'hAA);
      send(vt[i].addr);
      if (!vt[i].is_rd) send(vt[i].data);
      else begin
        @(negedge CLK);
        RdData = vt[i].data; RdData_Valid = 1'b1;
        @(negedge CLK);
        RdData_Valid = 1'b0;
      end
      repeat (8) @(negedge CLK);
      chk($sformatf("v%0d_wr_cnt", i), wr_cnt - w0, vt[i].exp_wr);
      chk($sformatf("v%0d_rd_cnt", i), rd_cnt - r0, vt[i].exp_rd);
      chk($sformatf("v%0d_tx_cnt", i), tx_cnt - t0, vt[i].exp_tx);
      if (vt[i].exp_wr) begin
        chk($sformatf("v%0d_wr_lat", i), wr_cyc - last_n, vt[i].exp_lat);
        chk($sformatf("v%0d_wr_addr", i), wr_addr, vt[i].addr[3:0]);
        chk($sformatf("v%0d_wr_data", i), wr_data, vt[i].data);
      end
      if (vt[i].exp_rd) begin
        chk($sformatf("v%0d_rd_lat", i), rd_cyc - last_n, 1);
        chk($sformatf("v%0d_rd_addr", i), rd_addr, vt[i].addr[3:0]);
      end
      if (vt[i].exp_tx) begin
        chk($sformatf("v%0d_tx_dat", i), tx_dat, vt[i].exp_dat);
        chk($sformatf("v%0d_tx_lat", i), tx_cyc - last_n, vt[i].exp_lat);
      end
      chk($sformatf("v%0d_idle", i), Ctrl_Busy, 1'b0);
    end

    // Read with RdData_Valid withheld -> error byte after the read window.
    r0 = rd_cnt; t0 = tx_cnt;
    send(8'hBB); send(8'h01);
    repeat (10) @(negedge CLK);
    chk("rdto_rd_cnt", rd_cnt - r0, 1);
    chk("rdto_tx_cnt", tx_cnt - t0, 1);
    chk("rdto_tx_dat", tx_dat, 8'hEE);
    chk("rdto_tx_lat", tx_cyc - last_n, 6);

    // Transmitter busy: reply must wait until TX_Busy falls.
    t0 = tx_cnt;
    TX_Busy = 1'b1;
    send(8'hBB); send(8'h05);
    @(negedge CLK);
    RdData = 8'h3C; RdData_Valid = 1'b1;
    @(negedge CLK);
    RdData_Valid = 1'b0;
    repeat (8) @(negedge CLK);
    chk("busy_no_tx", tx_cnt - t0, 0);
    chk("busy_ctrl_busy", Ctrl_Busy, 1'b1);
    TX_Busy = 1'b0;
    f = cyc;
    repeat (3) @(negedge CLK);
    chk("busy_tx_cnt", tx_cnt - t0, 1);
    chk("busy_tx_lat", tx_cyc - f, 1);
    chk("busy_tx_dat", tx_dat, 8'h3C);
    chk("busy_tx_bad", tx_bad, 0);

    // Frame timeout after a lone write opcode.
    w0 = wr_cnt;
    send(8'hAA);
    n0 = last_n;
    wait_to(n0 + 255);
    chk("fto_still_busy", Ctrl_Busy, 1'b1);
    wait_to(n0 + 256);
    chk("fto_idle", Ctrl_Busy, 1'b0);
    send(8'h03); send(8'h5C);
    repeat (4) @(negedge CLK);
    chk("fto_no_wr", wr_cnt - w0, 0);

    // A byte in the final cycle of the frame window is still accepted.
    send(8'hAA);
    n0 = last_n;
    wait_to(n0 + 255);
    send_now(8'h06);
    send(8'h99);
    repeat (3) @(negedge CLK);
    chk("fedge_wr_cnt", wr_cnt - w0, 1);
    chk("fedge_wr_addr", wr_addr, 4'h6);
    chk("fedge_wr_data", wr_data, 8'h99);

    // Stray byte in IDLE.
    w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt;
    send(8'h37);
    @(negedge CLK);
    chk("stray_busy", Ctrl_Busy, 1'b0);
    chk("stray_strobes", (wr_cnt - w0) + (rd_cnt - r0) + (tx_cnt - t0), 0);

    // Reset while waiting for write data.
    w0 = wr_cnt;
    send(8'hAA); send(8'h02);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    reset_chk("midrst");
    @(negedge CLK);
    RST = 1'b1;
    send(8'h44);
    repeat (4) @(negedge CLK);
    chk("midrst_no_wr", wr_cnt - w0, 0);
    chk("midrst_idle", Ctrl_Busy, 1'b0);

    chk("wr_rd_overlap", both_hi, 0);
    chk("strobe_width", long_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
